irrig_seq_ctrl: RTL and testbench

IRRIG_SEQ_CTRL -- requirements
Module: irrig_seq_ctrl

---
 rtl/irrig_seq_ctrl.sv | 118 +++++++++++
 tb/tb_irrig_seq_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrig_seq_ctrl.sv
// rtl/irrig_seq_ctrl.sv - sequential irrigation valve controller (scan / load / run per channel)
module irrig_seq_ctrl #(
    parameter int NCH = 4,
    parameter int TW  = 4
) (
    input  logic                     i_ck,
    input  logic                     i_clr,
    input  logic                     i_start,
    input  logic                     i_abort,
    input  logic                     i_mode,
    input  logic [NCH-1:0]           i_sens,
    input  logic [NCH*TW-1:0]        i_dur,
    output logic [NCH-1:0]           o_valve,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [$clog2(NCH)-1:0]   o_chan,
    output logic [TW-1:0]            o_remain
);

    localparam int CW = $clog2(NCH);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SCAN = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_chan;
    logic [TW-1:0]   r_timer;

    logic [TW-1:0]   w_dur_c;
    logic            w_last;
    logic            w_elig;
    logic            w_dry;
    logic            w_run_end;

    // Per-channel view of the current channel's inputs
    assign w_dur_c   = i_dur[r_chan*TW +: TW];
    assign w_last    = (r_chan == CW'(NCH - 1));
    assign w_elig    = (~i_mode | i_sens[r_chan]) & (w_dur_c != '0);
    assign w_dry     = i_mode & ~i_sens[r_chan];
    // A timer at or below 1 ends the channel, so a zero capture can never wrap
    assign w_run_end = (r_timer <= TW'(1)) | w_dry;

    // Sequencer: state, channel index and countdown timer
    always_ff @(posedge i_ck or negedge i_clr) begin
        if (!i_clr) begin
            r_state <= S_IDLE;
            r_chan  <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_SCAN;
                        r_chan  <= '0;
                    end
                end
                S_SCAN: begin
                    if (i_abort) begin
                        r_state <= S_DONE;
                    end else if (w_elig) begin
                        r_state <= S_LOAD;
                    end else if (w_last) begin
                        r_state <= S_DONE;
                    end else begin
                        r_chan  <= r_chan + CW'(1);
                    end
                end
                S_LOAD: begin
                    if (i_abort) begin
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= w_dur_c;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_state <= S_DONE;
                        r_timer <= '0;
                    end else if (w_run_end) begin
                        r_timer <= '0;
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SCAN;
                            r_chan  <= r_chan + CW'(1);
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_chan  <= '0;
                    r_timer <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_chan  <= '0;
                    r_timer <= '0;
                end
            endcase
        end
    end

    // Moore outputs decoded only from registered state, index and timer
    assign o_valve  = (r_state == S_RUN) ? (NCH'(1) << r_chan) : '0;
    assign o_busy   = (r_state != S_IDLE);
    assign o_done   = (r_state == S_DONE);
    assign o_chan   = r_chan;
    assign o_remain = (r_state == S_RUN) ? r_timer : '0;

endmodule

// File: tb/tb_irrig_seq_ctrl.sv
// tb/tb_irrig_seq_ctrl.sv - self-checking bench for irrig_seq_ctrl
module tb_irrig_seq_ctrl;

    localparam int NCH = 4;
    localparam int TW  = 4;
    localparam int CW  = 2;

    logic              ck;
    logic              clr;
    logic              start;
    logic              abort;
    logic              mode;
    logic [NCH-1:0]    sens;
    logic [NCH*TW-1:0] dur;
    logic [NCH-1:0]    o_valve;
    logic              o_busy;
    logic              o_done;
    logic [CW-1:0]     o_chan;
    logic [TW-1:0]     o_remain;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_open [NCH];
    int n_busy;
    int n_done;

    irrig_seq_ctrl #(.NCH(NCH), .TW(TW)) dut (
        .i_ck     (ck),
        .i_clr    (clr),
        .i_start  (start),
        .i_abort  (abort),
        .i_mode   (mode),
        .i_sens   (sens),
        .i_dur    (dur),
        .o_valve  (o_valve),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_chan   (o_chan),
        .o_remain (o_remain)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Expected output for one cycle; is_scan marks entries where eligibility is re-judged
    typedef struct packed {
        logic [NCH-1:0] valve;
        logic           busy;
        logic           done;
        logic [CW-1:0]  chan;
        logic [TW-1:0]  remain;
        logic           is_scan;
    } exp_t;

    exp_t m_cur = '0;
    exp_t m_q[$];

    function automatic exp_t mk(logic [NCH-1:0] v, logic b, logic d, logic [CW-1:0] c,
                                logic [TW-1:0] r, logic s);
        exp_t e;
        e.valve = v; e.busy = b; e.done = d; e.chan = c; e.remain = r; e.is_scan = s;
        return e;
    endfunction

    function automatic logic [TW-1:0] dur_of(int ch);
        logic [NCH*TW-1:0] d;
        d = dur;
        return d[ch*TW +: TW];
    endfunction

    // Whole remaining watering plan from channel c onward, as a cycle-by-cycle list
    function automatic void plan_from(int c);
        m_q.delete();
        for (int ch = c; ch < NCH; ch++) begin
            m_q.push_back(mk('0, 1'b1, 1'b0, CW'(ch), '0, 1'b1));
            if ((!mode || sens[ch]) && dur_of(ch) != '0) begin
                m_q.push_back(mk('0, 1'b1, 1'b0, CW'(ch), '0, 1'b0));
                for (int t = int'(dur_of(ch)); t >= 1; t--)
                    m_q.push_back(mk(NCH'(1) << ch, 1'b1, 1'b0, CW'(ch), TW'(t), 1'b0));
            end
        end
        m_q.push_back(mk('0, 1'b1, 1'b1, '0, '0, 1'b0));
    endfunction

    // Reference model: advance the plan, replanning on scans, dry drops and aborts
    always @(posedge ck or negedge clr) begin
        if (!clr) begin
            m_cur = '0;
            m_q.delete();
        end else if (!m_cur.busy) begin
            if (start) begin
                plan_from(0);
                m_cur = m_q.pop_front();
            end
        end else if (m_cur.done) begin
            m_cur = '0;
        end else if (abort) begin
            m_cur = mk('0, 1'b1, 1'b1, '0, '0, 1'b0);
        end else if (m_cur.valve != '0 && mode && !sens[m_cur.chan]) begin
            if (int'(m_cur.chan) == NCH - 1) begin
                m_cur = mk('0, 1'b1, 1'b1, '0, '0, 1'b0);
            end else begin
                plan_from(int'(m_cur.chan) + 1);
                m_cur = m_q.pop_front();
            end
        end else if (m_cur.is_scan) begin
            plan_from(int'(m_cur.chan));
            m_cur = m_q.pop_front();
            m_cur = m_q.pop_front();
        end else if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
        end else begin
            m_cur = '0;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge, compare against the model, accumulate counters
    task automatic tick();
        exp_t got;
        @(negedge ck);
        got        = m_cur;
        got.valve  = o_valve;
        got.busy   = o_busy;
        got.done   = o_done;
        got.remain = o_remain;
        if (m_cur.busy && !m_cur.done) got.chan = o_chan;
        n_checks++;
        if (got !== m_cur) begin
            n_errors++;
            $display("FAIL model_cmp t=%0t: valve=%b/%b busy=%b/%b done=%b/%b chan=%0d/%0d remain=%0d/%0d (got/expected)",
                     $time, o_valve, m_cur.valve, o_busy, m_cur.busy, o_done, m_cur.done,
                     o_chan, m_cur.chan, o_remain, m_cur.remain);
        end
        for (int ch = 0; ch < NCH; ch++) cnt_open[ch] += int'(o_valve[ch]);
        n_busy += int'(o_busy);
        n_done += int'(o_done);
    endtask

    task automatic clr_counts();
        for (int ch = 0; ch < NCH; ch++) cnt_open[ch] = 0;
        n_busy = 0;
        n_done = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy && n < 300) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(o_busy), 32'd0);
    endtask

    task automatic wait_valve(logic [NCH-1:0] v);
        int n = 0;
        while (o_valve !== v && n < 200) begin
            tick();
            n++;
        end
        chk("valve_timeout", 32'(o_valve), 32'(v));
    endtask

    task automatic chk_opens(string tag, int c0, int c1, int c2, int c3, int dn);
        chk({tag, "_open0"}, cnt_open[0], c0);
        chk({tag, "_open1"}, cnt_open[1], c1);
        chk({tag, "_open2"}, cnt_open[2], c2);
        chk({tag, "_open3"}, cnt_open[3], c3);
        chk({tag, "_done"},  n_done, dn);
    endtask

    initial begin
        clr   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        sens  = '0;
        dur   = '0;
        clr_counts();

        // Reset state
        tick();
        chk("rst_busy",   32'(o_busy),   32'd0);
        chk("rst_valve",  32'(o_valve),  32'd0);
        chk("rst_done",   32'(o_done),   32'd0);
        chk("rst_chan",   32'(o_chan),   32'd0);
        chk("rst_remain", 32'(o_remain), 32'd0);
        clr = 1'b1;
        tick();
        tick();
        chk("idle_hold", 32'(o_busy), 32'd0);

        // Mode 0, durations 3,0,2,1 with latency check
        mode = 1'b0;
        dur  = {4'd1, 4'd2, 4'd0, 4'd3};
        clr_counts();
        pulse_start();
        chk("t1_scan_chan", 32'(o_chan),  32'd0);
        chk("t1_scan_valve", 32'(o_valve), 32'd0);
        tick();
        chk("t1_load_valve", 32'(o_valve), 32'd0);
        tick();
        chk("t1_run_valve",  32'(o_valve),  32'b0001);
        chk("t1_run_remain", 32'(o_remain), 32'd3);
        wait_idle();
        chk_opens("t1", 3, 0, 2, 1, 1);
        chk("t1_busy_cycles", n_busy, 14);

        // Mode 1, sensors 1010, all durations 2; Start held and ignored while busy
        mode = 1'b1;
        sens = 4'b1010;
        dur  = {4'd2, 4'd2, 4'd2, 4'd2};
        clr_counts();
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        wait_idle();
        chk_opens("t2", 0, 2, 0, 2, 1);
        chk("t2_busy_cycles", n_busy, 11);

        // Mode 1, ch0 runs 8 but dries in its 4th cycle; Dur change mid-run is ignored
        mode = 1'b1;
        sens = 4'b1111;
        dur  = {4'd1, 4'd1, 4'd1, 4'd8};
        clr_counts();
        pulse_start();
        tick();
        tick();
        chk("t3_run_remain", 32'(o_remain), 32'd8);
        tick();
        dur[3:0] = 4'd2;
        tick();
        tick();
        chk("t3_run4_remain", 32'(o_remain), 32'd5);
        sens = 4'b1110;
        tick();
        chk("t3_after_valve", 32'(o_valve), 32'd0);
        chk("t3_after_chan",  32'(o_chan),  32'd1);
        wait_idle();
        chk_opens("t3", 4, 1, 1, 1, 1);

        // Abort in the 2nd RUN cycle of ch2
        mode = 1'b0;
        sens = 4'b0000;
        dur  = {4'd3, 4'd3, 4'd3, 4'd3};
        clr_counts();
        pulse_start();
        wait_valve(4'b0100);
        tick();
        chk("t4_run2_remain", 32'(o_remain), 32'd2);
        abort = 1'b1;
        tick();
        chk("t4_abort_valve", 32'(o_valve), 32'd0);
        chk("t4_abort_done",  32'(o_done),  32'd1);
        abort = 1'b0;
        tick();
        chk("t4_idle", 32'(o_busy), 32'd0);
        wait_idle();
        chk_opens("t4", 3, 3, 2, 0, 1);

        // Asynchronous reset mid-RUN on ch1, then a clean restart from ch0
        clr_counts();
        pulse_start();
        wait_valve(4'b0010);
        tick();
        #3 clr = 1'b0;
        #1;
        chk("t5_clr_valve",  32'(o_valve),  32'd0);
        chk("t5_clr_busy",   32'(o_busy),   32'd0);
        chk("t5_clr_done",   32'(o_done),   32'd0);
        chk("t5_clr_chan",   32'(o_chan),   32'd0);
        chk("t5_clr_remain", 32'(o_remain), 32'd0);
        tick();
        #2 clr = 1'b1;
        tick();
        tick();
        chk("t5_idle_after_clr", 32'(o_busy), 32'd0);
        clr_counts();
        pulse_start();
        tick();
        tick();
        chk("t5_restart_valve", 32'(o_valve), 32'b0001);
        wait_idle();
        chk_opens("t5", 3, 3, 3, 3, 1);

        // Nothing eligible: all durations zero
        mode = 1'b0;
        dur  = '0;
        clr_counts();
        pulse_start();
        wait_idle();
        chk_opens("t6a", 0, 0, 0, 0, 1);
        chk("t6a_busy_cycles", n_busy, 5);

        // Nothing eligible: mode 1 with every sensor wet
        mode = 1'b1;
        sens = 4'b0000;
        dur  = {4'd3, 4'd3, 4'd3, 4'd3};
        clr_counts();
        pulse_start();
        wait_idle();
        chk_opens("t6b", 0, 0, 0, 0, 1);
        chk("t6b_busy_cycles", n_busy, 5);

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
